// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared constants for the bit-serial adder/subtractor.
//   SAC_WIDTH            default operand/result width
//   ST_IDLE/ST_RUN/ST_DONE  FSM state encoding (legacy 2-bit values)
package serial_adder_ctrl_pkg;

  localparam int SAC_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: request/result bundle of the serial adder.
//   master: drives start/sub/A/B/Cin, observes busy/done/S/Cout/Ovf
//   slave : the adder block itself
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = SAC_WIDTH
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;

  modport master (
    output start, sub, A, B, Cin,
    input  busy, done, S, Cout, Ovf
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output busy, done, S, Cout, Ovf
  );

endinterface

// File: rtl/sum_complete.sv
// sum_complete: gate-level one-bit full adder.
//   A, B, Cin : addend bits and carry-in
//   S, Cout   : sum bit and carry-out
module sum_complete (
  output logic S,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);

  logic p;

  assign p    = A ^ B;
  assign S    = p ^ Cin;
  assign Cout = (A & B) | (p & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract, one bit per clock, LSB first.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of serial_adder_ctrl_if (start/sub/A/B/Cin in,
//           busy/done/S/Cout/Ovf out)
// An operation takes WIDTH RUN cycles followed by one DONE cycle; results
// hold through IDLE until the next accepted start.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = SAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_adder_ctrl_if.slave    bus
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_s;
  logic             fa_co;

  // Ripple incrementer built from xor/and so the counter needs no '+'.
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    c = 1'b1;
    for (int i = 0; i < CW; i++) begin
      r[i] = v[i] ^ c;
      c    = v[i] & c;
    end
    return r;
  endfunction

  sum_complete u_fa (
    .S    (fa_s),
    .Cout (fa_co),
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Cin  (carry_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            // subtract = A + ~B + 1: invert B here, force carry-in to 1
            b_q     <= bus.sub ? ~bus.B : bus.B;
            carry_q <= bus.sub | bus.Cin;
            cnt     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q   <= {fa_s, res_q[WIDTH-1:1]};
          carry_q <= fa_co;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt     <= inc(cnt);
          if (cnt == LAST) begin
            // carry_q still holds the carry into the MSB this cycle
            cout_q <= fa_co;
            ovf_q  <= carry_q ^ fa_co;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = (state == ST_DONE);
  assign bus.S    = res_q;
  assign bus.Cout = cout_q;
  assign bus.Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: table vectors, random ops against an arithmetic
// model, and hand sequences for interlock, mid-run reset and back-to-back.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb,
                       output logic [W-1:0] s, output logic co, output logic ov);
    int sa, sbv, r;
    logic [W:0] t;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (sb) begin
      s  = a - b;
      co = (a >= b);
      r  = sa - sbv;
    end else begin
      t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      s  = t[W-1:0];
      co = t[W];
      r  = sa + sbv + int'(ci);
    end
    ov = (r > 127) || (r < -128);
  endtask

  // Issue one op, wait for done (bounded), check latency and the idle hold.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb,
                        output logic [W-1:0] s, output logic co, output logic ov);
    int lat;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Cin = ci; bus.sub = sb; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(W));
    s = bus.S; co = bus.Cout; ov = bus.Ovf;
    @(posedge clk); #1;
    chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_S"}, 32'(bus.S), 32'(s));
  endtask

  vec_t         tbl[8];
  logic [W-1:0] gs, es;
  logic         gc, ec, go, eo;
  int           lat, ndone, bad;
  int           dq[$];

  initial begin
    n_tests = 0; n_fail = 0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0};
    tbl[4] = '{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[7] = '{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

    // reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_S",    32'(bus.S),    32'd0);
    chk("rst_Cout", 32'(bus.Cout), 32'd0);
    chk("rst_Ovf",  32'(bus.Ovf),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // directed table
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, gs, gc, go);
      chk($sformatf("vec%0d_S", i),    32'(gs), 32'(tbl[i].s));
      chk($sformatf("vec%0d_Cout", i), 32'(gc), 32'(tbl[i].cout));
      chk($sformatf("vec%0d_Ovf", i),  32'(go), 32'(tbl[i].ovf));
    end

    // random against model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      model(ra, rb, rc, rs, es, ec, eo);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, gs, gc, go);
      chk($sformatf("rnd%0d_S", i),    32'(gs), 32'(es));
      chk($sformatf("rnd%0d_Cout", i), 32'(gc), 32'(ec));
      chk($sformatf("rnd%0d_Ovf", i),  32'(go), 32'(eo));
    end

    // start pulsed during RUN with other operands is ignored
    @(negedge clk);
    bus.A = 8'h5A; bus.B = 8'h3C; bus.Cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 50) begin
      if (lat == 3) begin
        bus.A = 8'h11; bus.B = 8'h22; bus.sub = 1'b1; bus.start = 1'b1;
      end else bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("lock_latency", 32'(lat), 32'(W));
    chk("lock_S",    32'(bus.S),    32'h96);
    chk("lock_Ovf",  32'(bus.Ovf),  32'd1);
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("lock_no_second_done", 32'(ndone), 32'd0);
    chk("lock_S_held", 32'(bus.S), 32'h96);

    // reset in the middle of RUN
    @(negedge clk);
    bus.A = 8'hF0; bus.B = 8'h0F; bus.Cin = 1'b1; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_S",    32'(bus.S),    32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_Cout", 32'(bus.Cout), 32'd0);
    chk("mid_rst_Ovf",  32'(bus.Ovf),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    run_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, gs, gc, go);
    chk("post_rst_S", 32'(gs), 32'h02);

    // start held high: done every W+2 cycles, flags stable across the run
    @(negedge clk);
    bus.A = 8'h5A; bus.B = 8'h3C; bus.Cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    bad = 0;
    for (int t = 0; t < 45; t++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dq.push_back(t);
        chk($sformatf("b2b_S%0d", dq.size()), 32'(bus.S), 32'h96);
      end
      if (dq.size() > 0 && (bus.Cout !== 1'b0 || bus.Ovf !== 1'b1)) bad++;
    end
    bus.start = 1'b0;
    chk("b2b_flags_stable", 32'(bad), 32'd0);
    chk("b2b_enough_pulses", 32'(dq.size() >= 3), 32'd1);
    for (int i = 1; i < dq.size(); i++)
      chk($sformatf("b2b_gap%0d", i), 32'(dq[i] - dq[i-1]), 32'(W + 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
